// File: rtl/sample_scheduler.sv
// Per-sample timebase and two-phase (operator, then channel) sequencer with overrun detection.
// Optional macro SAMPLE_SCHEDULER_OVERRUN_CNT_EN builds the saturating overrun counter.
module sample_scheduler #(
    parameter int CLK_DIV           = 256,
    parameter int OVERRUN_CNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    output logic                         sample_clk_en,
    output logic                         ops_start,
    input  logic                         ops_done,
    output logic                         chan_start,
    input  logic                         chan_done,
    output logic                         busy,
    output logic                         overrun,
    input  logic                         overrun_clr,
    output logic [OVERRUN_CNT_WIDTH-1:0] overrun_cnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        OPS_WAIT  = 2'b01,
        CHAN_WAIT = 2'b10
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             sce_q;
    logic             sce_d;
    logic             ops_start_q;
    logic             chan_start_q;
    logic             busy_q;
    logic             overrun_q;
    logic             ovr_set;

    // Divider next state: hold at zero while disabled, pulse on the wrap.
    always_comb begin
        div_d = div_q;
        sce_d = 1'b0;
        if (!enable) begin
            div_d = {DIV_W{1'b0}};
        end else if (div_q == DIV_LAST) begin
            div_d = {DIV_W{1'b0}};
            sce_d = 1'b1;
        end else begin
            div_d = div_q + DIV_ONE;
        end
    end

    // Divider and sample enable registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= {DIV_W{1'b0}};
            sce_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sce_q <= sce_d;
        end
    end

    // A new sample arriving while a sequence is still in flight is an overrun.
    assign ovr_set = sce_q && (state_q != IDLE);

    // Sequencer FSM; a sample enable always restarts and discards any coincident done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ops_start_q  <= 1'b0;
            chan_start_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            ops_start_q  <= 1'b0;
            chan_start_q <= 1'b0;
            if (sce_q) begin
                state_q     <= OPS_WAIT;
                ops_start_q <= 1'b1;
                busy_q      <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        busy_q <= 1'b0;
                    end
                    OPS_WAIT: begin
                        if (ops_done) begin
                            state_q      <= CHAN_WAIT;
                            chan_start_q <= 1'b1;
                        end
                    end
                    CHAN_WAIT: begin
                        if (chan_done) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
            if (ovr_set) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

`ifdef SAMPLE_SCHEDULER_OVERRUN_CNT_EN
    localparam logic [OVERRUN_CNT_WIDTH-1:0] CNT_ONE = OVERRUN_CNT_WIDTH'(1);
    localparam logic [OVERRUN_CNT_WIDTH-1:0] CNT_MAX = {OVERRUN_CNT_WIDTH{1'b1}};

    logic [OVERRUN_CNT_WIDTH-1:0] cnt_q;

    // Saturating overrun counter; a coincident clear still counts the new overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {OVERRUN_CNT_WIDTH{1'b0}};
        end else if (ovr_set) begin
            if (overrun_clr) begin
                cnt_q <= CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_ONE;
            end else begin
                cnt_q <= cnt_q;
            end
        end else if (overrun_clr) begin
            cnt_q <= {OVERRUN_CNT_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign overrun_cnt = cnt_q;
`else
    assign overrun_cnt = {OVERRUN_CNT_WIDTH{1'b0}};
`endif

    assign sample_clk_en = sce_q;
    assign ops_start     = ops_start_q;
    assign chan_start    = chan_start_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler: a CLK_DIV=8 / 2-bit-counter instance and a CLK_DIV=64 instance.
module tb_sample_scheduler;

`ifdef SAMPLE_SCHEDULER_OVERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, en_a = 1'b1, opsd_a = 1'b0, chd_a = 1'b0, clr_a = 1'b0;
    logic       sce_a, ops_a, chs_a, busy_a, ovr_a;
    logic [1:0] cnt_a;

    logic       rst_b = 1'b1, en_b = 1'b1, opsd_b = 1'b0, chd_b = 1'b0, clr_b = 1'b0;
    logic       sce_b, ops_b, chs_b, busy_b, ovr_b;
    logic [7:0] cnt_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    sample_scheduler #(.CLK_DIV(8), .OVERRUN_CNT_WIDTH(2)) dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a),
        .sample_clk_en(sce_a), .ops_start(ops_a), .ops_done(opsd_a),
        .chan_start(chs_a), .chan_done(chd_a), .busy(busy_a),
        .overrun(ovr_a), .overrun_clr(clr_a), .overrun_cnt(cnt_a)
    );

    sample_scheduler #(.CLK_DIV(64), .OVERRUN_CNT_WIDTH(8)) dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b),
        .sample_clk_en(sce_b), .ops_start(ops_b), .ops_done(opsd_b),
        .chan_start(chs_b), .chan_done(chd_b), .busy(busy_b),
        .overrun(ovr_b), .overrun_clr(clr_b), .overrun_cnt(cnt_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    task automatic check_a_zero(input string tag);
        check_eq({tag, "_sce"},  32'(sce_a),  32'd0);
        check_eq({tag, "_ops"},  32'(ops_a),  32'd0);
        check_eq({tag, "_chs"},  32'(chs_a),  32'd0);
        check_eq({tag, "_busy"}, 32'(busy_a), 32'd0);
        check_eq({tag, "_ovr"},  32'(ovr_a),  32'd0);
        check_eq({tag, "_cnt"},  32'(cnt_a),  32'd0);
    endtask

    initial begin
        cyc = 0;
        tick();
        tick();
        check_a_zero("rst");
        check_eq("rst_b_busy", 32'(busy_b), 32'd0);

        // Free-run, saturation and clear on instance A.
        rst_a = 1'b0;
        for (int c = 1; c <= 57; c++) begin
            tick();
            cyc = c;
            check_eq("fr_sce", 32'(sce_a), 32'(c % 8 == 0));
            check_eq("fr_ops", 32'(ops_a), 32'((c % 8 == 1) && (c >= 9)));
            check_eq("fr_chs", 32'(chs_a), 32'd0);
            check_eq("fr_ovr", 32'(ovr_a), 32'(((c >= 17) && (c <= 50)) || (c >= 57)));
            if (c == 16) check_eq("fr_cnt0", 32'(cnt_a), exp_cnt(0));
            if (c == 26) check_eq("fr_cnt2", 32'(cnt_a), exp_cnt(2));
            if (c == 49) check_eq("sat_cnt", 32'(cnt_a), exp_cnt(3));
            if (c == 51) check_eq("clr_cnt", 32'(cnt_a), exp_cnt(0));
            if (c == 57) check_eq("clr_set_cnt", 32'(cnt_a), exp_cnt(1));
            clr_a = ((c == 50) || (c == 56));
        end

        // Stray dones, normal handshake, enable drop and re-enable.
        for (int c = 58; c <= 90; c++) begin
            tick();
            cyc = c;
            check_eq("sq_sce",  32'(sce_a),  32'((c == 64) || (c == 88)));
            check_eq("sq_ops",  32'(ops_a),  32'((c == 65) || (c == 89)));
            check_eq("sq_chs",  32'(chs_a),  32'((c == 61) || (c == 67)));
            check_eq("sq_busy", 32'(busy_a), 32'((c <= 62) || ((c >= 65) && (c <= 70)) || (c >= 89)));
            check_eq("sq_ovr",  32'(ovr_a),  32'd1);
            check_eq("sq_cnt",  32'(cnt_a),  exp_cnt(1));
            opsd_a = ((c == 60) || (c == 63) || (c == 66));
            chd_a  = ((c == 58) || (c == 62) || (c == 70));
            if (c == 67) en_a = 1'b0;
            if (c == 80) en_a = 1'b1;
        end

        // Asynchronous reset while in OPS_WAIT.
        #2;
        rst_a = 1'b1;
        #1;
        check_a_zero("arst");
        tick();
        tick();
        #2;
        rst_a = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            cyc = c;
            check_eq("ar_sce", 32'(sce_a), 32'(c == 8));
            check_eq("ar_ops", 32'(ops_a), 32'(c == 9));
            check_eq("ar_ovr", 32'(ovr_a), 32'd0);
        end

        // Normal sequence on instance B: ops_done 10 after ops_start, chan_done 20 after chan_start.
        rst_b = 1'b0;
        for (int k = 1; k <= 704; k++) begin
            int r;
            tick();
            cyc = k;
            r = k % 64;
            check_eq("ns_sce",  32'(sce_b),  32'(r == 0));
            check_eq("ns_ops",  32'(ops_b),  32'((k >= 65) && (r == 1)));
            check_eq("ns_chs",  32'(chs_b),  32'((k >= 65) && (r == 12)));
            check_eq("ns_busy", 32'(busy_b), 32'((k >= 65) && (r >= 1) && (r <= 32)));
            check_eq("ns_ovr",  32'(ovr_b),  32'd0);
            opsd_b = ((k >= 65) && (r == 11));
            chd_b  = ((k >= 65) && (r == 32));
        end
        check_eq("ns_cnt", 32'(cnt_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
